// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: ASCII constants and drain-FSM encodings.
package uart_tx_fifo_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        TXF_IDLE      = 2'd0,
        TXF_SEND      = 2'd1,
        TXF_WAIT_LOW  = 2'd2,
        TXF_WAIT_HIGH = 2'd3
    } txf_state_t;

    function automatic logic is_lf(input logic [7:0] b);
        return (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Send/ready handshake between the transmit buffer and the UART controller.
interface uart_tx_fifo_if;
    logic [7:0] tx_dat;
    logic       tx_send;
    logic       tx_ready;

    modport master (output tx_dat, output tx_send, input tx_ready);
    modport slave  (input tx_dat, input tx_send, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// DEPTH x 8 synchronous FIFO with registered occupancy flags; writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage carries no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers characters for the UART controller and drains them over the send/ready handshake.
// Define UART_TX_CRLF_EN to expand each LF into CR LF on the way out.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   CLK100MHZ,
    input  logic                   rst_n,
    input  logic [7:0]             char_in,
    input  logic                   char_wen,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    uart_tx_fifo_if.master         tx,
    output logic [1:0]             debug_state
);
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    txf_state_t    state;
    txf_state_t    state_nxt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    head;
    logic [7:0]    send_byte;
    logic          pop;
    logic          load_dat;
    logic          insert_cr;
    logic          drop;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CLK100MHZ),
        .rst_n   (rst_n),
        .wr_en   (char_wen),
        .wr_data (char_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

`ifdef UART_TX_CRLF_EN
    logic cr_flag;

    // The LF stays at the head while its CR goes out, so the flag marks "CR already sent".
    assign insert_cr = is_lf(head) && !cr_flag;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            cr_flag <= 1'b0;
        end else if (state == TXF_SEND) begin
            cr_flag <= insert_cr;
        end
    end
`else
    assign insert_cr = 1'b0;
`endif

    assign send_byte   = insert_cr ? ASCII_CR : head;
    assign drop        = char_wen && full;
    assign tx.tx_send  = (state == TXF_SEND);
    assign debug_state = state;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_dat  = 1'b0;
        case (state)
            TXF_IDLE: begin
                if (!empty && tx.tx_ready) begin
                    state_nxt = TXF_SEND;
                    load_dat  = 1'b1;
                end
            end
            TXF_SEND: begin
                pop       = !insert_cr;
                state_nxt = TXF_WAIT_LOW;
            end
            TXF_WAIT_LOW: begin
                // A controller that never drops ready must not stall the drain forever.
                if (!tx.tx_ready) begin
                    state_nxt = TXF_WAIT_HIGH;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = TXF_IDLE;
                end
            end
            TXF_WAIT_HIGH: begin
                if (tx.tx_ready) begin
                    state_nxt = TXF_IDLE;
                end
            end
            default: state_nxt = TXF_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state <= TXF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == TXF_SEND) begin
            to_cnt <= '0;
        end else if (state == TXF_WAIT_LOW && tx.tx_ready && to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Loaded on entry to SEND so the byte is valid during the send pulse.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            tx.tx_dat <= 8'h00;
        end else if (load_dat) begin
            tx.tx_dat <= send_byte;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a monitor checks each tx_send.
module tb_uart_tx_fifo;
    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 16;

    logic       CLK100MHZ = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] char_in   = 8'h00;
    logic       char_wen  = 1'b0;
    logic       ovf_clr   = 1'b0;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [4:0] count;
    logic [1:0] debug_state;

    uart_tx_fifo_if txif();

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .CLK100MHZ   (CLK100MHZ),
        .rst_n       (rst_n),
        .char_in     (char_in),
        .char_wen    (char_wen),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .tx          (txif),
        .debug_state (debug_state)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         mode     = 0;   // 0: drops ready 3 cycles after a send, 1: ready low, 2: ready high
    int         since    = 100;
    logic [7:0] sb_q[$];
    int         send_cyc_q[$];
    logic [7:0] exp_b;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        char_in  = b;
        char_wen = 1'b1;
        tick();
        char_wen = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || debug_state != 2'd0 || !empty) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, sb_q.size());
        end
    endtask

    // Controller model.
    initial begin
        txif.tx_ready = 1'b1;
        forever begin
            @(posedge CLK100MHZ);
            #1;
            if (txif.tx_send === 1'b1) since = 0;
            else if (since < 100) since++;
            case (mode)
                1:       txif.tx_ready = 1'b0;
                2:       txif.tx_ready = 1'b1;
                default: txif.tx_ready = !(since >= 3 && since <= 6);
            endcase
        end
    end

    // Monitor.
    initial begin
        forever begin
            @(posedge CLK100MHZ);
            #2;
            if (txif.tx_send === 1'b1) begin
                send_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_send: got tx_dat=0x%0h expected no send", txif.tx_dat);
                end else begin
                    exp_b = sb_q.pop_front();
                    chk("tx_dat", {24'h0, txif.tx_dat}, {24'h0, exp_b});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gap;
        int n;
        int sends_before;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_send", txif.tx_send, 0);
        chk("rst_tx_dat", txif.tx_dat, 8'h00);
        chk("rst_overflow", overflow, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_state", debug_state, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte latency
        sb_q.push_back(8'h41);
        wr(8'h41);
        chk("t1_empty", empty, 0);
        chk("t1_count", count, 1);
        tick();
        chk("t1_send_n2", txif.tx_send, 1);
        chk("t1_dat_n2", txif.tx_dat, 8'h41);
        wait_drain("t1_drain");
        chk("t1_empty_after", empty, 1);

        // Fill to full and overflow
        mode = 1;
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb_q.push_back(8'(i));
            wr(8'(i));
            if (i == 15) begin
                chk("t2_full", full, 1);
                chk("t2_count16", count, 16);
                chk("t2_no_ovf_yet", overflow, 0);
            end
        end
        chk("t2_overflow", overflow, 1);
        chk("t2_count_after_drop", count, 16);
        mode = 0;
        wait_drain("t2_drain");
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", overflow, 1);

        // Overflow clear, and set winning over clear
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_clr", overflow, 0);
        mode = 1;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'h80 + 8'(i));
            wr(8'h80 + 8'(i));
        end
        chk("t3_full", full, 1);
        wr(8'hEE);
        chk("t3_ovf_set", overflow, 1);
        char_in  = 8'hEF;
        char_wen = 1'b1;
        ovf_clr  = 1'b1;
        tick();
        char_wen = 1'b0;
        ovf_clr  = 1'b0;
        chk("t3_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_clr2", overflow, 0);
        mode = 0;
        wait_drain("t3_drain");

        // LF handling
        sb_q.push_back(8'h31);
`ifdef UART_TX_CRLF_EN
        sb_q.push_back(8'h0D);
`endif
        sb_q.push_back(8'h0A);
        wr(8'h31);
        wr(8'h0A);
        wait_drain("t4_drain");
        chk("t4_count", count, 0);

        // Controller that never drops ready
        mode = 2;
        repeat (5) tick();
        send_cyc_q.delete();
        sb_q.push_back(8'h55);
        sb_q.push_back(8'h66);
        wr(8'h55);
        wr(8'h66);
        wait_drain("t5_drain");
        chk("t5_sends", send_cyc_q.size(), 2);
        gap = (send_cyc_q.size() >= 2) ? (send_cyc_q[1] - send_cyc_q[0]) : -1;
        chk("t5_gap", gap, BUSY_TIMEOUT + 2);

        // Reset in WAIT_HIGH with 5 bytes buffered
        mode = 0;
        repeat (10) tick();
        sb_q.push_back(8'hA0);
        for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i));
        n = 0;
        while (debug_state != 2'd3 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_reached_wait_high", debug_state, 3);
        chk("t6_count5", count, 5);
        sends_before = send_cyc_q.size();
        rst_n = 1'b0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_tx_send", txif.tx_send, 0);
        chk("t6_state", debug_state, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("t6_no_more_sends", send_cyc_q.size(), sends_before);
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Character buffer between `char_stager` and `UART_controller` on the UART transmit path. Absorbs bursts of result/echo characters (e.g. a full matrix dump) into a small synchronous FIFO and drains them one byte at a time using the controller's send/ready handshake. Gives `char_stager` back-pressure through `full`. Optionally expands LF into CR LF for terminal output.

## Interface
Parameters:
- `DEPTH`, 16, number of FIFO entries; must be a power of two and at least 2.
- `BUSY_TIMEOUT`, 16, cycles to wait for `tx_ready` to fall after a send before treating the byte as accepted.

Ports (one clock; reset is asynchronous and active-low):
- `CLK100MHZ`, input, 1, system clock. All logic is rising-edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `char_in`, input, 8, character from `char_stager`.
- `char_wen`, input, 1, one-cycle write strobe for `char_in`.
- `full`, output, 1, FIFO holds `DEPTH` entries.
- `empty`, output, 1, FIFO holds 0 entries.
- `count`, output, $clog2(DEPTH)+1, current occupancy.
- `overflow`, output, 1, sticky flag: a write was dropped.
- `ovf_clr`, input, 1, clears `overflow`.
- `tx_dat`, output, 8, byte to `UART_controller` (`UART_TX_DAT`).
- `tx_send`, output, 1, one-cycle send pulse (`UART_TX_SEND`).
- `tx_ready`, input, 1, controller idle (`UART_TX_READY`).
- `debug_state`, output, 2, FSM state, intended for the LED mux.

## Operation
- Write path:
  - `char_wen` with `!full` stores `char_in` at the write pointer. The pointer wraps modulo `DEPTH`.
  - `char_wen` while `full` drops the byte and sets `overflow`. This holds even if a pop happens in the same cycle.
- `overflow` stays set until `ovf_clr`. If `ovf_clr` and a dropped write occur in the same cycle, set wins.
- Drain FSM states: IDLE=0, SEND=1, WAIT_LOW=2, WAIT_HIGH=3.
  - IDLE -> SEND when `!empty && tx_ready`.
  - SEND lasts exactly one cycle. It registers the head byte into `tx_dat`, pulses `tx_send`, and pops the FIFO (except for the CR insertion case under Configuration). It then moves to WAIT_LOW and clears the timeout counter.
  - WAIT_LOW -> WAIT_HIGH when `tx_ready==0`.
  - WAIT_LOW -> IDLE when the counter reaches `BUSY_TIMEOUT-1` with `tx_ready` still high.
  - WAIT_HIGH -> IDLE when `tx_ready==1`.
- A push and a pop in the same cycle leave `count` unchanged.
- `tx_dat` holds its value between sends.
- Reset values:
  - `tx_send`=0, `tx_dat`=0x00, `overflow`=0.
  - `full`=0, `empty`=1, `count`=0, `debug_state`=0.
  - Pointers, the timeout counter and the CR flag are all 0.
- Reset asserted mid-transfer discards all buffered bytes and deasserts `tx_send` immediately. A byte already accepted by the controller still completes on the line.

## Timing
- `char_wen` in cycle N: `empty` falls and `count` increments at N+1.
- With the FSM in IDLE and `tx_ready` high, `tx_send` is high in cycle N+2 and `tx_dat` is valid in that same cycle.
- `count` decrements in the cycle after SEND.
- Minimum spacing between `tx_send` pulses is 4 cycles: SEND, WAIT_LOW, WAIT_HIGH, IDLE.
- `full`, `empty` and `count` are registered and update one cycle after the push or pop.
- Throughput is bounded by the UART byte time, which is far slower than these limits.

## Configuration
- `UART_TX_CRLF_EN` defined:
  - A head byte of 0x0A with the CR flag clear is sent as 0x0D without popping, and the CR flag is set.
  - The next SEND transmits 0x0A, pops, and clears the CR flag.
  - Any other byte passes unchanged.
- `UART_TX_CRLF_EN` undefined: the CR flag logic is absent and every byte is sent verbatim, one SEND per entry.

## Structure
- Shared header `my_header.vh` gains:
  - `ASCII_LF` (8'h0A) and `ASCII_CR` (8'h0D).
  - Drain-state encodings `TXF_IDLE`, `TXF_SEND`, `TXF_WAIT_LOW`, `TXF_WAIT_HIGH`.
- One sub-module, `sync_fifo`:
  - Contents: DEPTH x 8 storage, read/write pointers, `count`, `full`/`empty`.
  - The drain FSM, timeout counter and CR logic live in the top of this block.

## Test plan
- Reset, then write 0x41 with `tx_ready` held high and dropped 3 cycles after each send. Expect one `tx_send` pulse with `tx_dat`=0x41 exactly 2 cycles after `char_wen`, and `empty`=1 afterwards.
- With `tx_ready` held low, write 17 bytes 0x00..0x10 (DEPTH=16). Expect `full`=1 after the 16th write, 0x10 dropped and `overflow`=1. After releasing `tx_ready`, expect 0x00..0x0F sent in order.
- Pulse `ovf_clr` while `overflow` is set. Expect `overflow`=0 the next cycle. Repeat with a dropped write in the same cycle and expect `overflow` to stay 1.
- With `UART_TX_CRLF_EN` defined, write 0x31, 0x0A. Expect sends 0x31, 0x0D, 0x0A and `count` back to 0. With the macro undefined, expect 0x31, 0x0A only.
- Hold `tx_ready` constantly high (controller never drops ready) and write 2 bytes. Expect two sends spaced by `BUSY_TIMEOUT`+2 cycles, with no hang.
- Assert `rst_n`=0 while 5 bytes are buffered and the FSM is in WAIT_HIGH. Expect `count`=0, `empty`=1, `tx_send`=0 and `debug_state`=0 immediately, and no further sends after release.
